// File: rtl/ls_pkg.sv
// Shared widths, FSM state encoding and the request record carried through
// the load/store responder's request buffer.
package ls_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } ls_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              r_nw;
    logic [TAG_W-1:0]  tag;
  } ls_req_t;

endpackage

// File: rtl/ls_req_fifo.sv
// In-order request buffer. Read/write pointers carry one extra MSB so that
// full and empty are told apart without a separate occupancy counter.
module ls_req_fifo
  import ls_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  ls_req_t push_data,
  input  logic    pop,
  output ls_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  ls_req_t          mem_q [DEPTH];
  ls_req_t          mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ls_responder.sv
// Memory-side responder for the load/store port: buffers requests, issues one
// single-cycle byte access each, and returns load bytes (or a timeout error) to writeback.
module ls_responder #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 8,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_R_nW,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [15:0]       wb_data,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              wb_err,
  output logic              busy
);

  import ls_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Handshakes: a transfer happens on any rising edge where valid && ready.
  // Request side: req_ready depends only on registered FIFO state, never on
  // req_valid. Writeback side: once wb_valid rises, wb_valid/wb_data/wb_tag/
  // wb_err hold unchanged until the edge where wb_ready is also high.

  ls_state_e         state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              wb_valid_q, wb_valid_d;
  logic [15:0]       wb_data_q, wb_data_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic              wb_err_q, wb_err_d;

  ls_req_t           push_req, head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign push_req  = '{addr: req_addr, data: req_data, r_nw: req_R_nW, tag: req_tag};
  assign fifo_push = req_valid && !fifo_full;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  ls_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_tag_d    = wb_tag_q;
    wb_err_d    = wb_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = !head.r_nw;
          mem_addr_d  = head.addr;
          mem_wdata_d = head.data;
          tag_d       = head.tag;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // mem_we_q describes the access being strobed this cycle.
        if (mem_we_q) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = !head.r_nw;
            mem_addr_d  = head.addr;
            mem_wdata_d = head.data;
            tag_d       = head.tag;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = '0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = {{(16-DATA_W){1'b0}}, mem_rdata};
          wb_err_d   = 1'b0;
          wb_tag_d   = tag_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 16'h0000;
            wb_err_d   = 1'b1;
            wb_tag_d   = tag_q;
            state_d    = RESP;
          end
        end
      end
      RESP: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_tag_q    <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_tag_q    <= wb_tag_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_tag    = wb_tag_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_ls_responder.sv
// Self-checking bench for ls_responder: scenario tasks, a behavioural memory
// that answers loads, and a monitor that scores accesses and writebacks.
module tb_ls_responder;

  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              req_R_nW = 1'b0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic              wb_valid;
  logic              wb_ready = 1'b1;
  logic [15:0]       wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic              wb_err;
  logic              busy;

  ls_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .FIFO_DEPTH(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_R_nW(req_R_nW), .req_tag(req_tag),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .wb_err(wb_err), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [ADDR_W+DATA_W:0] exp_mem_q[$];   // {we, addr, wdata}
  logic [TAG_W+16:0]      exp_wb_q[$];    // {err, tag, data}
  logic [TAG_W-1:0]       load_tag_q[$];
  logic [TAG_W-1:0]       wb_tag_log[$];
  int                     accept_cyc = 0;

  // ---------------- memory model ----------------
  bit         resp_en = 1'b1;
  bit         rand_lat = 1'b0;
  bit         stray_req = 1'b0;
  bit         rand_ready = 1'b0;
  int         resp_lat = 2;
  int         rd_countdown = 0;
  logic [7:0] rd_byte = '0;

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hE0;
  endfunction

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_countdown > 0) begin
      rd_countdown--;
      if (rd_countdown == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_byte;
      end
    end
    if (stray_req) begin
      stray_req  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h3C;
    end
    if (mem_en && !mem_we && resp_en && !rst) begin
      rd_countdown = rand_lat ? int'($urandom_range(1, 6)) : resp_lat;
      rd_byte      = mem_byte(mem_addr);
      if (load_tag_q.size() > 0)
        exp_wb_q.push_back({1'b0, load_tag_q.pop_front(), 8'h00, rd_byte});
    end
    if (rand_ready) wb_ready = ($urandom_range(0, 2) != 0);
  end

  // ---------------- monitor ----------------
  bit                 prev_hold = 1'b0;
  logic [TAG_W+16:0]  prev_wb = '0;
  int                 mem_run = 0;
  int                 max_run = 0;
  bit                 wb_seen = 1'b0;

  always @(negedge clk) begin
    logic [ADDR_W+DATA_W:0] exp_m;
    logic [TAG_W+16:0]      exp_w;
    #2;
    if (!rst) begin
      if (mem_en) begin
        mem_run++;
        if (mem_run > max_run) max_run = mem_run;
        n_tests++;
        if (exp_mem_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_access: unexpected access we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
        end else begin
          exp_m = exp_mem_q.pop_front();
          if ({mem_we, mem_addr, mem_wdata} !== exp_m) begin
            n_fail++;
            $display("FAIL mem_access: got %h want %h", {mem_we, mem_addr, mem_wdata}, exp_m);
          end
        end
      end else begin
        mem_run = 0;
      end
      if (wb_valid) wb_seen = 1'b1;
      if (prev_hold) begin
        n_tests++;
        if (!wb_valid || {wb_err, wb_tag, wb_data} !== prev_wb) begin
          n_fail++;
          $display("FAIL wb_hold: got v=%b %h want v=1 %h", wb_valid, {wb_err, wb_tag, wb_data}, prev_wb);
        end
      end
      if (wb_valid && wb_ready) begin
        wb_tag_log.push_back(wb_tag);
        n_tests++;
        if (exp_wb_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_result: unexpected writeback %h", {wb_err, wb_tag, wb_data});
        end else begin
          exp_w = exp_wb_q.pop_front();
          if ({wb_err, wb_tag, wb_data} !== exp_w) begin
            n_fail++;
            $display("FAIL wb_result: got %h want %h", {wb_err, wb_tag, wb_data}, exp_w);
          end
        end
      end
      prev_hold = wb_valid && !wb_ready;
      prev_wb   = {wb_err, wb_tag, wb_data};
    end else begin
      prev_hold = 1'b0;
      mem_run   = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_req(input logic r_nw, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    int guard = 0;
    req_valid = 1'b1;
    req_R_nW  = r_nw;
    req_addr  = a;
    req_data  = d;
    req_tag   = t;
    while (!req_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL req_accept: req_ready=%b after %0d cycles, want 1", req_ready, guard);
    end else begin
      accept_cyc = cyc;
      exp_mem_q.push_back({~r_nw, a, d});
      if (r_nw) load_tag_q.push_back(t);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_mem_en(input string name);
    int guard = 0;
    while (!mem_en && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (!mem_en) begin
      n_fail++;
      $display("FAIL %s: mem_en=%b after %0d cycles, want 1", name, mem_en, guard);
    end
  endtask

  task automatic wait_wb_valid(input string name);
    int guard = 0;
    while (!wb_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (!wb_valid) begin
      n_fail++;
      $display("FAIL %s: wb_valid=%b after %0d cycles, want 1", name, wb_valid, guard);
    end
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((busy || exp_wb_q.size() != 0 || exp_mem_q.size() != 0 || rd_countdown != 0)
           && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL %s: not drained, busy=%b mem_q=%0d wb_q=%0d, want idle and empty",
               name, busy, exp_mem_q.size(), exp_wb_q.size());
    end
  endtask

  task automatic check_reset_values(input string name);
    n_tests++;
    if ({mem_en, mem_we, wb_valid, wb_err, busy, req_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL %s_ctrl: en/we/wbv/err/busy/rdy=%b want 000001", name,
               {mem_en, mem_we, wb_valid, wb_err, busy, req_ready});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, wb_data, wb_tag} !== '0) begin
      n_fail++;
      $display("FAIL %s_regs: addr=%h wdata=%h wb_data=%h wb_tag=%h want all 0", name,
               mem_addr, mem_wdata, wb_data, wb_tag);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_values("reset");
  endtask

  task automatic test_single_load();
    int t;
    resp_lat = 2;
    send_req(1'b1, 25'h1_2345, 8'h00, 5'd7);
    t = accept_cyc;
    wait_mem_en("single_mem_en");
    n_tests++;
    if (cyc - t != 2 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue: mem_en at +%0d we=%b, want +2 we=0", cyc - t, mem_we);
    end
    tick(1);
    n_tests++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_strobe: mem_en=%b want 0", mem_en);
    end
    wait_wb_valid("single_wb_valid");
    n_tests++;
    if (cyc - t != 5 || wb_data !== 16'h00A5 || wb_tag !== 5'd7 || wb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_wb: at +%0d data=%h tag=%0d err=%b, want +5 00a5 7 0",
               cyc - t, wb_data, wb_tag, wb_err);
    end
    wait_idle("single_drain");
  endtask

  task automatic test_back_to_back();
    max_run = 0;
    wb_seen = 1'b0;
    send_req(1'b0, 25'd0, 8'h11, 5'd0);
    send_req(1'b0, 25'd1, 8'h22, 5'd1);
    send_req(1'b0, 25'd2, 8'h33, 5'd2);
    wait_idle("b2b_drain");
    n_tests++;
    if (max_run != 3) begin
      n_fail++;
      $display("FAIL b2b_run: consecutive mem_en=%0d want 3", max_run);
    end
    n_tests++;
    if (wb_seen) begin
      n_fail++;
      $display("FAIL b2b_no_wb: wb_valid seen=%b want 0", wb_seen);
    end
  endtask

  task automatic test_backpressure();
    resp_lat = 3;
    wb_ready = 1'b0;
    send_req(1'b1, 25'h0_0A11, 8'h00, 5'd12);
    send_req(1'b0, 25'd5, 8'h55, 5'd0);
    send_req(1'b0, 25'd6, 8'h66, 5'd0);
    n_tests++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: req_ready=%b busy=%b want 0 1", req_ready, busy);
    end
    wait_wb_valid("bp_wb_valid");
    for (int i = 0; i < 6; i++) begin
      if (i == 5) wb_ready = 1'b1;
      n_tests++;
      if (!wb_valid || wb_data !== 16'h00F1 || wb_tag !== 5'd12 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b data=%h tag=%0d en=%b want 1 00f1 12 0",
                 i, wb_valid, wb_data, wb_tag, mem_en);
      end
      tick(1);
    end
    wait_idle("bp_drain");
  endtask

  task automatic test_timeout();
    int c;
    resp_en = 1'b0;
    send_req(1'b1, 25'h1_FFFF, 8'h00, 5'd21);
    exp_wb_q.push_back({1'b1, load_tag_q.pop_front(), 16'h0000});
    wait_mem_en("to_mem_en");
    c = cyc;
    wait_wb_valid("to_wb_valid");
    n_tests++;
    if (cyc - c != TIMEOUT + 1 || wb_err !== 1'b1 || wb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL to_result: at +%0d err=%b data=%h, want +%0d 1 0000",
               cyc - c, wb_err, wb_data, TIMEOUT + 1);
    end
    wait_idle("to_drain");
    wb_seen = 1'b0;
    stray_req = 1'b1;
    tick(5);
    n_tests++;
    if (wb_seen || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_stray: wb_seen=%b busy=%b want 0 0", wb_seen, busy);
    end
    resp_en  = 1'b1;
    resp_lat = TIMEOUT;
    send_req(1'b1, 25'h0_0077, 8'h00, 5'd4);
    wait_idle("to_boundary");
    resp_lat = 2;
  endtask

  task automatic test_reset_wait();
    resp_lat = 6;
    send_req(1'b1, 25'h0_1234, 8'h00, 5'd2);
    wait_mem_en("rw_mem_en");
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_wb_q.delete();
    exp_mem_q.delete();
    load_tag_q.delete();
    check_reset_values("rst_wait");
    wb_seen = 1'b0;
    tick(8);
    n_tests++;
    if (wb_seen || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_late_rvalid: wb_seen=%b busy=%b ready=%b want 0 0 1", wb_seen, busy, req_ready);
    end
    resp_lat = 2;
  endtask

  task automatic test_mixed_order();
    resp_lat = 1;
    wb_tag_log.delete();
    send_req(1'b1, 25'h0_0100, 8'h00, 5'd3);
    send_req(1'b0, 25'h0_0101, 8'hAB, 5'd0);
    send_req(1'b1, 25'h0_0102, 8'h00, 5'd9);
    wait_idle("mixed_drain");
    n_tests++;
    if (wb_tag_log.size() != 2 || wb_tag_log[0] !== 5'd3 || wb_tag_log[1] !== 5'd9) begin
      n_fail++;
      $display("FAIL mixed_tags: count=%0d first=%0d second=%0d want 2 3 9", wb_tag_log.size(),
               wb_tag_log.size() > 0 ? wb_tag_log[0] : 5'd0, wb_tag_log.size() > 1 ? wb_tag_log[1] : 5'd0);
    end
    resp_lat = 2;
  endtask

  task automatic test_random();
    rand_lat   = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send_req(1'($urandom_range(0, 1)), ADDR_W'($urandom()), DATA_W'($urandom()),
               TAG_W'($urandom()));
      tick($urandom_range(0, 2));
    end
    wait_idle("random_drain");
    rand_lat   = 1'b0;
    rand_ready = 1'b0;
    wb_ready   = 1'b1;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_mixed_order();
    test_random();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ls_responder.md
# ls_responder

Memory-side responder for the Execute stage's load/store port. It accepts one request per handshake: 25-bit address, 8-bit store data, read/write flag and 5-bit destination tag. Requests are buffered in a small FIFO and each one drives a single-cycle access on the byte-wide external memory port. For loads it waits for variable-latency read data, then returns the zero-extended byte with its tag to writeback, holding it until writeback accepts.

## Interface
Parameters:
- ADDR_W, 25, memory address width ({R1[8:0], R0})
- DATA_W, 8, memory data width
- TAG_W, 5, destination-register tag width
- FIFO_DEPTH, 2, request buffer entries (power of two, ≥2)
- TIMEOUT, 255, max cycles waiting for mem_rvalid before error completion

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_addr  in  ADDR_W  byte address
- req_data  in  DATA_W  store data
- req_R_nW  in  1  1 = load, 0 = store
- req_tag  in  TAG_W  destination tag, meaningful for loads only
- mem_en  out  1  access strobe, exactly one cycle per request
- mem_we  out  1  write enable, valid with mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  read data
- mem_rvalid  in  1  read data valid, one-cycle pulse
- wb_valid  out  1  load result available
- wb_ready  in  1  writeback accepts
- wb_data  out  16  {8'b0, byte}, or 16'h0000 on error
- wb_tag  out  TAG_W  tag of completing load
- wb_err  out  1  load timed out
- busy  out  1  FIFO non-empty or state ≠ IDLE

## Operation
- Accept on req_valid && req_ready. Push into FIFO in order. req_ready = !full, with no same-cycle pass-through when full.
- FSM states are IDLE, ISSUE, WAIT_RD and RESP.
- **IDLE:** if FIFO non-empty, pop the head, load mem_addr/mem_we/mem_wdata and the pending tag, then go to ISSUE.
- **ISSUE:** mem_en = 1.
  - Store with FIFO non-empty: pop the next entry and stay in ISSUE. Back-to-back stores run at one per cycle.
  - Store with FIFO empty: go to IDLE.
  - Load: go to WAIT_RD and clear the timeout counter.
- **WAIT_RD:** mem_en = 0.
  - On mem_rvalid: wb_data ← {8'b0, mem_rdata}, wb_err ← 0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: wb_data ← 0, wb_err ← 1, go to RESP.
- **RESP:** wb_valid = 1, with data and tag held stable. When wb_ready is high, go to IDLE.
- mem_rvalid is ignored in every state except WAIT_RD.
- Stores generate no writeback. req_tag is ignored for stores.
- At most one load is outstanding. Memory order equals request order.

## Timing
- Reset values:
  - mem_en, mem_we, wb_valid, wb_err, busy = 0
  - mem_addr, mem_wdata, wb_data, wb_tag = 0
  - req_ready = 1
  - FIFO empty, state IDLE, counter 0
- Load latency, starting from an empty FIFO:
  - Accept at cycle t.
  - mem_en at t+2.
  - Earliest mem_rvalid at t+3.
  - wb_valid at t+4.
- Store latency: accept at t, mem_en with mem_we=1 at t+2.
- Handshake: a request accepted while the FIFO is full is impossible, because req_ready is low.
- Simultaneous push and pop when not full:
  - both occur;
  - occupancy is unchanged.
- wb_valid never drops without wb_ready. The wb_ready && wb_valid cycle is the final RESP cycle.
- Timeout boundary: a mem_rvalid arriving in the same cycle the counter reaches TIMEOUT takes priority, so the data completes normally.
- Reset mid-operation (any state):
  - FIFO flushed;
  - in-flight load abandoned;
  - a late mem_rvalid is ignored because the state is IDLE.
- All outputs are registered, except req_ready and busy, which decode from registered state.

## Structure
- Package ls_pkg:
  - ADDR_W, DATA_W, TAG_W;
  - ls_state_e enum (IDLE, ISSUE, WAIT_RD, RESP);
  - ls_req_t packed struct {addr, data, r_nw, tag}.
- Sub-module ls_req_fifo:
  - parameterised depth;
  - ls_req_t payload;
  - push/pop/full/empty ports;
  - synchronous reset;
  - pointer wrap by an extra MSB.

## Test plan
- Single load:
  - stimulus: addr 25'h1_2345, tag 5'd7; memory returns 8'hA5 two cycles after mem_en;
  - required: mem_en one cycle with mem_we=0, then wb_valid with wb_data=16'h00A5, wb_tag=7, wb_err=0.
- Three back-to-back stores, offered continuously:
  - stimulus: data 11/22/33 at addrs 0/1/2;
  - required: mem_en high for three consecutive cycles with matching addr/wdata, req_ready drops while the FIFO is full, and wb_valid is never asserted.
- Writeback backpressure:
  - stimulus: load completes while wb_ready is held low for 5 cycles;
  - required: wb_valid, wb_data and wb_tag stay stable for 6 cycles, and the queued next request is not issued until acceptance.
- Timeout:
  - stimulus: load with mem_rvalid never asserted;
  - required: after TIMEOUT cycles, wb_valid=1, wb_err=1, wb_data=16'h0000. A later stray mem_rvalid has no effect.
- Reset in WAIT_RD:
  - stimulus: rst pulsed for one cycle, then mem_rvalid arrives;
  - required: all outputs return to their reset values, no writeback occurs, busy=0, req_ready=1.
- Mixed order:
  - stimulus: load (tag 3), store, load (tag 9);
  - required: memory accesses occur in request order, and writebacks come out tag 3 then tag 9.
